// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// fetch_unit : fetch PC, in-order multi-outstanding iCache requests, fetch queue
//              to decode. Optional macro FETCH_PERF_EN enables perf counters.
// Revision   : 1.0
// =============================================================================
module fetch_unit #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FQ_DEPTH        = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [31:0]     NOP_INSTR       = 32'h00000013
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [31:0]     dec_instr,
  output logic [31:0]     perf_delivered,
  output logic [31:0]     perf_starve,
  output logic [31:0]     perf_squashed
);

  localparam int unsigned c_qw = $clog2(FQ_DEPTH);
  localparam int unsigned c_ow = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned c_pw = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [c_pw-1:0] c_pf_last = c_pw'(MAX_OUTSTANDING - 1);

  logic [XLEN-1:0] r_fpc;
  logic [c_ow-1:0] r_out;
  logic [c_ow-1:0] r_drop;
  logic [c_ow-1:0] w_out_nxt;

  logic [c_pw-1:0] r_pf_wr;
  logic [c_pw-1:0] r_pf_rd;
  logic [XLEN-1:0] r_pf_mem [MAX_OUTSTANDING];

  logic [c_qw-1:0] r_q_wr;
  logic [c_qw-1:0] r_q_rd;
  logic [c_qw:0]   r_q_cnt;
  logic [XLEN-1:0] r_q_pc    [FQ_DEPTH];
  logic [31:0]     r_q_instr [FQ_DEPTH];

  logic [31:0] w_inflight;
  logic        w_fire;
  logic        w_rsp_live;
  logic        w_pop;

  function automatic logic [c_pw-1:0] pf_inc(input logic [c_pw-1:0] p);
    return (p == c_pf_last) ? '0 : p + c_pw'(1);
  endfunction

  // Credit: live requests plus queued entries may never exceed the queue size,
  // so every live response is guaranteed a slot.
  assign w_inflight     = 32'(r_out) - 32'(r_drop) + 32'(r_q_cnt);
  assign imem_req_valid = reset && !redirect_valid &&
                          (32'(r_out) < MAX_OUTSTANDING) && (w_inflight < FQ_DEPTH);
  assign imem_req_addr  = r_fpc;
  assign w_fire         = imem_req_valid && imem_req_ready;
  assign w_rsp_live     = imem_rsp_valid && !redirect_valid && (r_drop == '0);

  assign dec_valid = (r_q_cnt != '0);
  assign dec_pc    = dec_valid ? r_q_pc[r_q_rd]    : '0;
  assign dec_instr = dec_valid ? r_q_instr[r_q_rd] : NOP_INSTR;
  assign w_pop     = dec_valid && dec_ready && !redirect_valid;

  always_comb begin
    w_out_nxt = r_out;
    if (w_fire && !imem_rsp_valid)
      w_out_nxt = r_out + c_ow'(1);
    else if (!w_fire && imem_rsp_valid)
      w_out_nxt = r_out - c_ow'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fpc  <= RESET_PC;
      r_out  <= '0;
      r_drop <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (redirect_valid) begin
        r_fpc  <= redirect_pc;
        // Everything still in flight belongs to the abandoned path.
        r_drop <= w_out_nxt;
      end else begin
        if (w_fire)
          r_fpc <= r_fpc + XLEN'(4);
        if (imem_rsp_valid && (r_drop != '0))
          r_drop <= r_drop - c_ow'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pf_wr <= '0;
      r_pf_rd <= '0;
    end else if (redirect_valid) begin
      r_pf_wr <= '0;
      r_pf_rd <= '0;
    end else begin
      if (w_fire)
        r_pf_wr <= pf_inc(r_pf_wr);
      if (w_rsp_live)
        r_pf_rd <= pf_inc(r_pf_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (w_fire)
      r_pf_mem[r_pf_wr] <= r_fpc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else if (redirect_valid) begin
      r_q_wr  <= '0;
      r_q_rd  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_rsp_live)
        r_q_wr <= r_q_wr + c_qw'(1);
      if (w_pop)
        r_q_rd <= r_q_rd + c_qw'(1);
      if (w_rsp_live && !w_pop)
        r_q_cnt <= r_q_cnt + (c_qw+1)'(1);
      else if (!w_rsp_live && w_pop)
        r_q_cnt <= r_q_cnt - (c_qw+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_rsp_live) begin
      r_q_pc[r_q_wr]    <= r_pf_mem[r_pf_rd];
      r_q_instr[r_q_wr] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_del;
  logic [31:0] r_perf_starve;
  logic [31:0] r_perf_sq;
  logic [31:0] w_sq_inc;

  always_comb begin
    w_sq_inc = 32'(imem_rsp_valid && (redirect_valid || (r_drop != '0)));
    if (redirect_valid)
      w_sq_inc = w_sq_inc + 32'(r_q_cnt);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_del    <= '0;
      r_perf_starve <= '0;
      r_perf_sq     <= '0;
    end else begin
      if (w_pop)
        r_perf_del <= r_perf_del + 32'd1;
      if (dec_ready && !dec_valid && !redirect_valid)
        r_perf_starve <= r_perf_starve + 32'd1;
      r_perf_sq <= r_perf_sq + w_sq_inc;
    end
  end

  assign perf_delivered = r_perf_del;
  assign perf_starve    = r_perf_starve;
  assign perf_squashed  = r_perf_sq;
`else
  assign perf_delivered = '0;
  assign perf_starve    = '0;
  assign perf_squashed  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// tb_fetch_unit : randomized scoreboard bench for fetch_unit (epoch-based model).
// Revision      : 1.0
// =============================================================================
module tb_fetch_unit;

  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned MAX_OUT  = 2;
  localparam logic [31:0] RST_PC   = 32'h0;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic [31:0] perf_delivered;
  logic [31:0] perf_starve;
  logic [31:0] perf_squashed;

  fetch_unit #(
    .XLEN(32), .RESET_PC(RST_PC), .FQ_DEPTH(FQ_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .NOP_INSTR(NOP)
  ) dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_pc(dec_pc), .dec_instr(dec_instr),
    .perf_delivered(perf_delivered), .perf_starve(perf_starve),
    .perf_squashed(perf_squashed)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  req_t pend[$];   // requests the memory model owes a response for
  exp_t sb[$];     // program-order instructions decode must still receive

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int epoch  = 0;
  int pops   = 0;
  logic [31:0] model_pc = RST_PC;
  logic        chk_first = 1'b0;
  logic [31:0] first_tgt = '0;

  int rdy_pct, dec_pct, rsp_pct, redir_pct, lat_lo, lat_hi;
  logic        do_redir = 1'b0;
  logic [31:0] redir_tgt = '0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle: called right after a rising edge.
  task automatic step();
    req_t p;
    logic [31:0] t;
    @(posedge clock); #1;
    cyc++;
    redirect_valid = 1'b0;
    if (do_redir || (redir_pct > 0 && $urandom_range(99) < redir_pct)) begin
      t = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) t = 32'hFFFF_FFF4;
      redirect_valid = 1'b1;
      redirect_pc    = do_redir ? redir_tgt : t;
      do_redir       = 1'b0;
    end
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    dec_ready      = ($urandom_range(99) < dec_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom();
    if (pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(p.addr);
      if (reset && !redirect_valid && p.epoch == epoch)
        sb.push_back('{p.addr, memf(p.addr)});
    end
    if (redirect_valid) begin
      sb.delete();
      epoch++;
      model_pc  = redirect_pc;
      chk_first = 1'b1;
      first_tgt = redirect_pc;
    end
  endtask

  // Monitor: compares decode output and request stream on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (dec_valid && dec_ready && !redirect_valid) begin
        pops++;
        if (sb.size() == 0) begin
          total++;
          $display("FAIL pop_unexpected: dec_pc=%0h instr=%0h with nothing expected", dec_pc, dec_instr);
        end else begin
          e = sb.pop_front();
          chk("dec_pc", dec_pc, e.pc);
          chk("dec_instr", dec_instr, e.instr);
        end
        if (chk_first) begin
          chk("redir_first_pc", dec_pc, first_tgt);
          chk_first = 1'b0;
        end
      end
      if (!dec_valid) chk("nop_when_empty", dec_instr, NOP);
      if (redirect_valid) chk("no_issue_on_redirect", imem_req_valid, 0);
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        pend.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), epoch});
        model_pc = model_pc + 32'd4;
      end
      chk("outstanding_bound", pend.size() <= MAX_OUT, 1);
      chk("queue_bound", sb.size() <= FQ_DEPTH, 1);
    end
  end

  initial begin
    logic [31:0] held;
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    rdy_pct = 100; dec_pct = 100; rsp_pct = 100; redir_pct = 0; lat_lo = 1; lat_hi = 1;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_pc", dec_pc, 0);
    chk("rst_dec_instr", dec_instr, NOP);
    repeat (3) step();
    reset = 1'b1;

    // Steady streaming: once warm, decode sees an instruction every cycle.
    repeat (6) step();
    repeat (20) begin
      step();
      chk("no_gap", dec_valid, 1);
    end

    // Decode stall: queue fills to exactly FQ_DEPTH and issue stops.
    dec_pct = 0;
    repeat (12) step();
    chk("stall_fill", sb.size(), FQ_DEPTH);
    chk("stall_no_req", imem_req_valid, 0);
    chk("stall_dec_valid", dec_valid, 1);

    // Redirect with requests in flight.
    dec_pct = 100; lat_lo = 3; lat_hi = 3;
    repeat (3) step();
    do_redir = 1'b1; redir_tgt = 32'h100;
    step();
    step();
    chk("flush_empty", dec_valid, 0);
    repeat (12) step();

    // Memory not ready: address held, decode starved.
    rdy_pct = 0; lat_lo = 1; lat_hi = 1;
    repeat (14) step();
    held = model_pc;
    repeat (5) begin
      step();
      chk("hold_addr", imem_req_addr, held);
      chk("hold_dec_valid", dec_valid, 0);
      chk("hold_dec_instr", dec_instr, NOP);
    end

    // Randomized traffic with redirects, including near the address wrap.
    rdy_pct = 70; dec_pct = 60; rsp_pct = 70; redir_pct = 4; lat_lo = 1; lat_hi = 4;
    repeat (600) step();

    // Reset mid-stream; late responses arrive while reset is held.
    rdy_pct = 100; dec_pct = 100; rsp_pct = 100; redir_pct = 0; lat_lo = 3; lat_hi = 3;
    repeat (6) step();
    reset = 1'b0;
    #1;
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_dec_valid", dec_valid, 0);
    chk("midrst_dec_instr", dec_instr, NOP);
    repeat (4) step();
    pend.delete(); sb.delete();
    model_pc = RST_PC; epoch++; chk_first = 1'b0;
    imem_rsp_valid = 1'b0;
    lat_lo = 1; lat_hi = 2;
    reset = 1'b1;
    repeat (30) step();

    // Drain with no new requests.
    rdy_pct = 0;
    for (int i = 0; i < 200 && (sb.size() != 0 || pend.size() != 0); i++) step();
    if (sb.size() != 0 || pend.size() != 0) begin
      total++;
      $display("FAIL drain_timeout: expected=%0d pending=%0d left, required 0", sb.size(), pend.size());
    end
    step();
    chk("drain_empty", dec_valid, 0);
    chk("liveness", pops > 150, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
